// File: rtl/pwm_fade_ctrl.sv
// Purpose: LED PWM sequencer; owns the 8-bit period counter and duty register, ramps duty (track/breathe/fade-out).
// Latency: duty/state update on the Count==255 edge of a ramp tick; new duty visible at Count==0; PwmOut is same-cycle.
// Backpressure: none; free-running, inputs sampled at update events only (Target also feeds AtTarget directly).
module pwm_fade_ctrl #(
  parameter int TICK_DIV = 195312,
  parameter int STEP_W   = 4
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic              Enable,
  input  logic              Mode,
  input  logic [7:0]        Target,
  input  logic [STEP_W-1:0] Step,
  output logic [7:0]        Duty,
  output logic [7:0]        Count,
  output logic              PwmOut,
  output logic              AtTarget,
  output logic [2:0]        State
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_TRACK = 3'd1,
    S_UP    = 3'd2,
    S_DOWN  = 3'd3,
    S_FADE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      duty_q, duty_d;
  logic [7:0]      count_q;
  logic [PW-1:0]   presc_q;
  logic            pend_q;
  logic            tick;
  logic            update;
  logic [8:0]      step9, duty9, tgt9;
  logic [8:0]      inc_sat, dec_zero, dec_tgt;

  // A tick that lands outside a period boundary is remembered in pend_q;
  // one landing exactly on the boundary is consumed directly.
  assign tick   = (presc_q == PRESC_LAST);
  assign update = (count_q == 8'hFF) && (pend_q || tick);

  // 9-bit saturating arithmetic so duty can never wrap.
  assign step9    = (Step == '0) ? 9'd1 : 9'(Step);
  assign duty9    = {1'b0, duty_q};
  assign tgt9     = {1'b0, Target};
  assign inc_sat  = ((duty9 + step9) > tgt9) ? tgt9 : (duty9 + step9);
  assign dec_zero = (step9 >= duty9) ? 9'd0 : (duty9 - step9);
  assign dec_tgt  = (duty9 < (tgt9 + step9)) ? tgt9 : (duty9 - step9);

  // Counter, prescaler and pending-tick flag.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= 8'd0;
      presc_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_q + 8'd1;
      presc_q <= tick ? '0 : (presc_q + PW'(1));
      if (update)    pend_q <= 1'b0;
      else if (tick) pend_q <= 1'b1;
    end
  end

  // FSM and duty register; only move on update events.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_OFF;
      duty_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  // Next state / next duty. Priority: Enable low, then mode switch, then step.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (update) begin
      case (state_q)
        S_OFF: begin
          duty_d = 8'd0;
          if (Enable) state_d = Mode ? S_UP : S_TRACK;
        end
        S_TRACK: begin
          if (!Enable)   state_d = S_FADE;
          else if (Mode) state_d = S_UP;
          else           duty_d  = (duty9 < tgt9) ? inc_sat[7:0] : dec_tgt[7:0];
        end
        S_UP: begin
          if (!Enable)    state_d = S_FADE;
          else if (!Mode) state_d = S_TRACK;
          else begin
            duty_d = inc_sat[7:0];
            if (inc_sat >= tgt9) state_d = S_DOWN;
          end
        end
        S_DOWN: begin
          if (!Enable)    state_d = S_FADE;
          else if (!Mode) state_d = S_TRACK;
          else begin
            duty_d = dec_zero[7:0];
            if (dec_zero == 9'd0) state_d = S_UP;
          end
        end
        S_FADE: begin
          if (Enable) state_d = Mode ? S_UP : S_TRACK;
          else begin
            duty_d = dec_zero[7:0];
            if (dec_zero == 9'd0) state_d = S_OFF;
          end
        end
        default: begin
          state_d = S_OFF;
          duty_d  = 8'd0;
        end
      endcase
    end
  end

  assign Duty     = duty_q;
  assign Count    = count_q;
  assign PwmOut   = (count_q < duty_q);
  assign AtTarget = (state_q == S_TRACK) && (duty_q == Target);
  assign State    = state_q;

endmodule
